// File: rtl/arb_rr_oht_if.sv
// Request/grant bundle for the round-robin one-hot arbiter.
// master: requester side, slave: arbiter side.
interface arb_rr_oht_if #(
   parameter int WIDTH = 16
);
   localparam int WIDTH_LOG = $clog2(WIDTH);

   logic [WIDTH-1:0]     req;
   logic                 gnt_vld;
   logic [WIDTH_LOG-1:0] gnt_bin;
   logic [WIDTH-1:0]     gnt;

   modport master (
      output req,
      input  gnt_vld,
      input  gnt_bin,
      input  gnt
   );

   modport slave (
      input  req,
      output gnt_vld,
      output gnt_bin,
      output gnt
   );
endinterface

// File: rtl/arb_rr_oht.sv
// Round-robin arbiter with registered binary grant, one-hot decode and an
// optional maximum grant length (HOLD, 0 = unlimited).

// Binary to one-hot decoder, split into a low field of SPLIT bits and a high
// field of the remaining bits whose partial decodes are ANDed together.
module bin2oht #(
   parameter int WIDTH = 16,
   parameter int SPLIT = 4
) (
   input  logic                     vld,
   input  logic [$clog2(WIDTH)-1:0] bin,
   output logic [WIDTH-1:0]         oht
);
   localparam int BW   = $clog2(WIDTH);
   localparam int LO_W = (SPLIT < 1) ? 1 : ((SPLIT < BW) ? SPLIT : BW);
   localparam int HI_W = BW - LO_W;
   localparam int LO_N = 1 << LO_W;
   localparam int HI_N = 1 << HI_W;

   logic [LO_N-1:0] lo_oht;
   logic [HI_N-1:0] hi_oht;

   // Decode the low field
   always_comb begin
      lo_oht = '0;
      lo_oht[bin[LO_W-1:0]] = 1'b1;
   end

   generate
      if (HI_W == 0) begin : g_no_hi
         // Whole index fits in the low field; the high stage only carries vld
         always_comb hi_oht = vld;
      end else begin : g_hi
         // Decode the high field, gated by vld
         always_comb begin
            hi_oht = '0;
            hi_oht[bin[BW-1:LO_W]] = vld;
         end
      end
   endgenerate

   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_oht
         assign oht[g] = hi_oht[g / LO_N] & lo_oht[g % LO_N];
      end
   endgenerate
endmodule

module arb_rr_oht #(
   parameter int WIDTH = 16,
   parameter int SPLIT = 4,
   parameter int HOLD  = 0
) (
   input logic          clk,
   input logic          rst,
   arb_rr_oht_if.slave  bus
);
   localparam int WIDTH_LOG = $clog2(WIDTH);
   localparam int CNT_W     = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (HOLD > 0) ? CNT_W'(HOLD - 1) : '0;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH_LOG-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 gnt_vld_q, gnt_vld_d;
   logic [WIDTH_LOG-1:0] gnt_bin_q, gnt_bin_d;

   logic [WIDTH_LOG-1:0] pick;
   logic [WIDTH_LOG-1:0] idx;
   logic                 found;
   logic                 hold_last;
   logic                 rel;

   // Find the first requester at or after ptr, wrapping through WIDTH-1 -> 0
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      idx   = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         idx = ptr_q + WIDTH_LOG'(i);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // Next-state, pointer, hold counter and grant register inputs
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      gnt_vld_d = gnt_vld_q;
      gnt_bin_d = gnt_bin_q;
      hold_last = (HOLD > 0) && (cnt_q == CNT_LAST);
      rel       = !bus.req[gnt_bin_q] || hold_last;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               state_d   = GRANT;
               gnt_vld_d = 1'b1;
               gnt_bin_d = pick;
               cnt_d     = '0;
            end
         end
         GRANT: begin
            // Release always returns to IDLE, so a requester that is dropped
            // and re-requests in the same cycle re-arbitrates from the new ptr
            if (rel) begin
               state_d   = IDLE;
               gnt_vld_d = 1'b0;
               ptr_d     = gnt_bin_q + 1'b1;
               cnt_d     = '0;
            end else if (HOLD > 0) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            gnt_vld_d = 1'b0;
         end
      endcase
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         gnt_vld_q <= 1'b0;
         gnt_bin_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         gnt_vld_q <= gnt_vld_d;
         gnt_bin_q <= gnt_bin_d;
      end
   end

   assign bus.gnt_vld = gnt_vld_q;
   assign bus.gnt_bin = gnt_bin_q;

   bin2oht #(
      .WIDTH (WIDTH),
      .SPLIT (SPLIT)
   ) u_bin2oht (
      .vld (gnt_vld_q),
      .bin (gnt_bin_q),
      .oht (bus.gnt)
   );
endmodule

// File: tb/tb_arb_rr_oht.sv
// Bench for arb_rr_oht: two instances (HOLD=0 and HOLD=4) share one request
// vector; a behavioural model tracks each and is compared every cycle.
module tb_arb_rr_oht;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] req = '0;

   int n_tests = 0;
   int n_fail  = 0;

   arb_rr_oht_if #(.WIDTH(16)) if0 ();
   arb_rr_oht_if #(.WIDTH(16)) if4 ();
   assign if0.req = req;
   assign if4.req = req;

   arb_rr_oht #(.WIDTH(16), .SPLIT(4), .HOLD(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   arb_rr_oht #(.WIDTH(16), .SPLIT(4), .HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

   always #5 clk = ~clk;

   typedef struct packed {
      logic busy;
      int   owner;
      int   ptr;
      int   len;
   } mdl_t;

   mdl_t m0, m4;

   // One cycle of arbitration: len counts cycles the current owner has held
   function automatic mdl_t step(input mdl_t m, input logic [15:0] r, input int hold);
      mdl_t n;
      logic hit;
      n = m;
      if (m.busy) begin
         if (!r[m.owner] || (hold > 0 && m.len >= hold)) begin
            n.busy = 1'b0;
            n.ptr  = (m.owner + 1) % 16;
         end else begin
            n.len = m.len + 1;
         end
      end else if (r != 16'h0) begin
         hit = 1'b0;
         for (int k = 0; k < 16; k++) begin
            if (!hit && r[(m.ptr + k) % 16]) begin
               hit     = 1'b1;
               n.owner = (m.ptr + k) % 16;
            end
         end
         n.busy = 1'b1;
         n.len  = 1;
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m0 <= '0;
         m4 <= '0;
      end else begin
         m0 <= step(m0, req, 0);
         m4 <= step(m4, req, 4);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_oht(input mdl_t m);
      return m.busy ? (32'd1 << m.owner) : 32'd0;
   endfunction

   // Model comparison every cycle, away from the rising edge
   always @(negedge clk) begin
      chk("d0_vld", 32'(if0.gnt_vld), 32'(m0.busy));
      chk("d0_bin", 32'(if0.gnt_bin), m0.owner);
      chk("d0_gnt", 32'(if0.gnt), ref_oht(m0));
      chk("d4_vld", 32'(if4.gnt_vld), 32'(m4.busy));
      chk("d4_bin", 32'(if4.gnt_bin), m4.owner);
      chk("d4_gnt", 32'(if4.gnt), ref_oht(m4));
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   int sel;

   initial begin
      // Reset state
      do_reset();
      chk("rst_gnt", 32'(if0.gnt), 32'h0);
      chk("rst_bin", 32'(if0.gnt_bin), 32'h0);

      // No requests for 10 cycles
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_vld", 32'(if0.gnt_vld), 32'h0);
         chk("idle_gnt", 32'(if0.gnt), 32'h0);
      end

      // 0x8001: grant 0, release, pointer moves past 0, then 15
      req = 16'h8001;
      @(negedge clk);
      chk("p27_bin0", 32'(if0.gnt_bin), 32'd0);
      chk("p27_gnt0", 32'(if0.gnt), 32'h0001);
      req = 16'h8000;
      @(negedge clk);
      chk("p27_rel", 32'(if0.gnt_vld), 32'h0);
      @(negedge clk);
      chk("p27_bin15", 32'(if0.gnt_bin), 32'd15);
      chk("p27_gnt15", 32'(if0.gnt), 32'h8000);
      req = 16'h0000;
      @(negedge clk);

      // All requesting: strict rotation with one idle cycle between grants
      req = 16'hFFFF;
      for (int k = 0; k <= 16; k++) begin
         @(negedge clk);
         chk("rr_vld", 32'(if0.gnt_vld), 32'h1);
         chk("rr_bin", 32'(if0.gnt_bin), k % 16);
         req = 16'hFFFF & ~(16'd1 << (k % 16));
         @(negedge clk);
         chk("rr_gap", 32'(if0.gnt_vld), 32'h0);
         req = (k == 16) ? 16'h0000 : 16'hFFFF;
      end

      // HOLD=4 with 0x0005 held: 0,2,0,2 each exactly 4 cycles
      do_reset();
      req = 16'h0005;
      for (int g = 0; g < 4; g++) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("hold_vld", 32'(if4.gnt_vld), 32'h1);
            chk("hold_bin", 32'(if4.gnt_bin), (g % 2 == 1) ? 32'd2 : 32'd0);
         end
         @(negedge clk);
         chk("hold_gap", 32'(if4.gnt_vld), 32'h0);
      end

      // Asynchronous reset mid-grant drops the grant and resets the pointer
      req = 16'h0000;
      do_reset();
      req = 16'h0080;
      @(negedge clk);
      chk("ar_bin7", 32'(if0.gnt_bin), 32'd7);
      #2 rst = 1'b1;
      #1;
      chk("ar_gnt", 32'(if0.gnt), 32'h0);
      chk("ar_vld", 32'(if0.gnt_vld), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      req = 16'h0081;
      @(negedge clk);
      chk("ar_bin0", 32'(if0.gnt_bin), 32'd0);
      chk("ar_gnt0", 32'(if0.gnt), 32'h0001);

      // Randomised traffic, including drops of the granted bit and resets
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         sel = int'($urandom_range(0, 99));
         if (sel < 15) begin
            req = 16'($urandom);
         end else if (sel < 25) begin
            req = 16'($urandom) & 16'($urandom) & 16'($urandom);
         end else if (sel < 45) begin
            req = req & ~(16'd1 << if0.gnt_bin);
         end else if (sel < 50) begin
            req = req | (16'd1 << $urandom_range(0, 15));
         end else if (sel < 52) begin
            #2 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/arb_rr_oht.md
ARB_RR_OHT -- requirements
Module: arb_rr_oht

Interface
REQ-001 Parameter WIDTH, default 16, number of requesters; SHALL be a power of two, >= 2.
REQ-002 Parameter SPLIT, default 4, SHALL be passed unchanged to the internal bin2oht one-hot decoder instance.
REQ-003 Parameter HOLD, default 0, maximum grant length in cycles; 0 SHALL mean unlimited.
REQ-004 Localparam WIDTH_LOG = $clog2(WIDTH) SHALL size all binary indices.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req  input  WIDTH  per-requester request level, held high until done.
REQ-008 gnt_vld  output  1  a grant is active.
REQ-009 gnt_bin  output  WIDTH_LOG  binary index of granted requester.
REQ-010 gnt  output  WIDTH  one-hot grant; SHALL equal bin2oht(gnt_vld, gnt_bin), all zeros when gnt_vld=0.

Function
REQ-011 FSM SHALL have two states: IDLE, GRANT.
REQ-012 Round-robin pointer ptr (WIDTH_LOG bits) SHALL mark the highest-priority requester; priority SHALL decrease with increasing index from ptr, wrapping WIDTH-1 -> 0.
REQ-013 IDLE with req != 0: next edge SHALL enter GRANT, gnt_vld=1, gnt_bin = first set req index at or after ptr (wrapping).
REQ-014 IDLE with req == 0: state, ptr, outputs SHALL remain unchanged (gnt_vld=0).
REQ-015 Grant latency SHALL be exactly 1 cycle from req sampled in IDLE to gnt_vld high.
REQ-016 GRANT: gnt_bin SHALL be held constant; changes on other req bits SHALL be ignored.
REQ-017 GRANT, req[gnt_bin]=0 sampled: release; next edge SHALL set gnt_vld=0, state IDLE, ptr = gnt_bin+1 mod WIDTH.
REQ-018 Hold counter cnt SHALL clear on grant entry and increment each GRANT cycle; with HOLD>0, when cnt reaches HOLD-1 and req[gnt_bin]=1, a forced release SHALL occur identical to REQ-017.
REQ-019 After any release the block SHALL spend exactly one cycle in IDLE before the next grant (no back-to-back grants).
REQ-020 Release and a new request from the same requester in the same cycle: release SHALL win; requester re-arbitrates from IDLE with updated ptr.
REQ-021 gnt_vld, gnt_bin, gnt SHALL be driven only from registers plus the combinational decoder; no combinational path req -> gnt.
REQ-022 Counter width SHALL be $clog2(HOLD+1) bits minimum; no overflow wrap SHALL occur when HOLD=0 (counter saturates or is unused).

Reset
REQ-023 rst=1 SHALL immediately (asynchronously) force state IDLE, ptr=0, cnt=0, gnt_vld=0, gnt_bin=0, gnt=0.
REQ-024 Reset asserted during GRANT SHALL drop the grant without pointer advance; first arbitration after rst deasserts SHALL start from index 0.
REQ-025 First rising edge with rst=0 SHALL be a normal IDLE evaluation.

Verification
REQ-026 WIDTH=16, reset then req=16'h0000 for 10 cycles -> gnt_vld=0, gnt=0 every cycle.
REQ-027 req=16'h8001 after reset -> gnt_bin=0, gnt=16'h0001 one cycle later; drop req[0] -> gnt_vld=0 next cycle, ptr=1; then gnt_bin=15, gnt=16'h8000.
REQ-028 req=16'hFFFF held, each requester dropping its bit for one cycle after granted -> grant order 0,1,2,...,15,0 with one idle cycle between grants.
REQ-029 HOLD=4, req=16'h0005 held constant -> grants alternate 0,2,0,2, each gnt_vld high exactly 4 cycles, one idle cycle between.
REQ-030 rst pulsed mid-GRANT (gnt_bin=7), asynchronous to clk -> gnt=0 before next edge; after release, req=16'h0081 -> gnt_bin=0.
REQ-031 All cycles: gnt SHALL be one-hot or zero and equal reference decode of (gnt_vld, gnt_bin).
